packet_read_responder: RTL and testbench

Buffer-side responder for the packet read-request interface issued by the packet readers. It accepts read requests (requestor id, page, line) and issues them to the flat buffer's line memory, which has a fixed read latency. It tags each returning line with its originating request and returns responses in strict request order over a valid/ready response channel. Credit-based admission guarantees that no memory read is ever issued without a free response slot, so responses are never dropped under response backpressure.

---
 rtl/packet_read_responder_if.sv | 45 ++++
 rtl/packet_read_responder.sv | 92 +++++++++
 tb/tb_packet_read_responder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/packet_read_responder_if.sv
// Read-request / memory / read-response bundle between the packet readers,
// the flat buffer line memory and the packet_read_responder.
interface packet_read_responder_if #(
   parameter int ID_W       = 2,
   parameter int PAGE_W     = 4,
   parameter int LINE_W     = 2,
   parameter int DATA_W     = 64,
   parameter int RESP_DEPTH = 4
);
   localparam int OCC_W = $clog2(RESP_DEPTH + 1);

   logic                     io_readReq_valid;
   logic                     io_readReq_ready;
   logic [ID_W-1:0]          io_readReq_bits_requestor;
   logic [PAGE_W-1:0]        io_readReq_bits_page;
   logic [LINE_W-1:0]        io_readReq_bits_line;
   logic                     io_mem_rd_en;
   logic [PAGE_W+LINE_W-1:0] io_mem_rd_addr;
   logic [DATA_W-1:0]        io_mem_rd_data;
   logic                     io_readResp_valid;
   logic                     io_readResp_ready;
   logic [ID_W-1:0]          io_readResp_bits_requestor;
   logic [PAGE_W-1:0]        io_readResp_bits_req_page;
   logic [LINE_W-1:0]        io_readResp_bits_req_line;
   logic [DATA_W-1:0]        io_readResp_bits_data;
   logic [OCC_W-1:0]         io_outstanding;

   // Responder side
   modport slave (
      input  io_readReq_valid, io_readReq_bits_requestor, io_readReq_bits_page,
             io_readReq_bits_line, io_mem_rd_data, io_readResp_ready,
      output io_readReq_ready, io_mem_rd_en, io_mem_rd_addr, io_readResp_valid,
             io_readResp_bits_requestor, io_readResp_bits_req_page,
             io_readResp_bits_req_line, io_readResp_bits_data, io_outstanding
   );

   // Reader / memory side
   modport master (
      output io_readReq_valid, io_readReq_bits_requestor, io_readReq_bits_page,
             io_readReq_bits_line, io_mem_rd_data, io_readResp_ready,
      input  io_readReq_ready, io_mem_rd_en, io_mem_rd_addr, io_readResp_valid,
             io_readResp_bits_requestor, io_readResp_bits_req_page,
             io_readResp_bits_req_line, io_readResp_bits_data, io_outstanding
   );
endinterface

// File: rtl/packet_read_responder.sv
// Buffer-side read responder: issues line reads to a fixed-latency memory,
// tags returning data with its request and returns responses in order.
// Admission is credit based (in-flight + queued <= RESP_DEPTH), so the
// response FIFO can never overflow under response backpressure.
module packet_read_responder #(
   parameter int ID_W       = 2,
   parameter int PAGE_W     = 4,
   parameter int LINE_W     = 2,
   parameter int DATA_W     = 64,
   parameter int MEM_LAT    = 2,
   parameter int RESP_DEPTH = 4
) (
   input logic                    clock,
   input logic                    reset,
   packet_read_responder_if.slave bus
);
   localparam int OCC_W = $clog2(RESP_DEPTH + 1);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int TAG_W = ID_W + PAGE_W + LINE_W;

   logic [OCC_W-1:0] occ;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic             vld_p [MEM_LAT];
   logic [TAG_W-1:0] tag_p [MEM_LAT];

   logic [TAG_W-1:0]  fifo_tag  [RESP_DEPTH];
   logic [DATA_W-1:0] fifo_data [RESP_DEPTH];

   logic             req_ready;
   logic             fire;
   logic             push;
   logic             pop;
   logic             resp_valid;
   logic [TAG_W-1:0] req_tag;
   logic [TAG_W-1:0] head_tag;

   // Credit check looks only at registered occupancy, never at valid.
   assign req_ready = (occ < OCC_W'(RESP_DEPTH));
   assign fire      = bus.io_readReq_valid & req_ready;
   assign req_tag   = {bus.io_readReq_bits_requestor, bus.io_readReq_bits_page,
                       bus.io_readReq_bits_line};

   assign bus.io_readReq_ready = req_ready;
   assign bus.io_mem_rd_en     = fire;
   assign bus.io_mem_rd_addr   = fire ? {bus.io_readReq_bits_page, bus.io_readReq_bits_line} : '0;

   // Memory data is valid exactly when the tag sits in the last pipeline stage.
   assign push       = vld_p[MEM_LAT-1];
   assign resp_valid = (count != '0);
   assign pop        = resp_valid & bus.io_readResp_ready;
   assign head_tag   = resp_valid ? fifo_tag[rd_ptr] : '0;

   assign bus.io_readResp_valid = resp_valid;
   assign {bus.io_readResp_bits_requestor, bus.io_readResp_bits_req_page,
           bus.io_readResp_bits_req_line} = head_tag;
   assign bus.io_readResp_bits_data = resp_valid ? fifo_data[rd_ptr] : '0;
   assign bus.io_outstanding        = occ;

   // Control state: tag valids, FIFO pointers/count and occupancy credit.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MEM_LAT; i++) vld_p[i] <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         occ    <= '0;
      end else begin
         vld_p[0] <= fire;
         for (int i = 1; i < MEM_LAT; i++) vld_p[i] <= vld_p[i-1];
         if (push) begin
            assert (count < (PTR_W+1)'(RESP_DEPTH));
            wr_ptr <= (wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
         occ   <= occ + OCC_W'(fire) - OCC_W'(pop);
      end
   end

   // Data path: tag shift pipeline and FIFO storage (not reset; gated by valids).
   always_ff @(posedge clock) begin
      tag_p[0] <= req_tag;
      for (int i = 1; i < MEM_LAT; i++) tag_p[i] <= tag_p[i-1];
      if (push) begin
         fifo_tag[wr_ptr]  <= tag_p[MEM_LAT-1];
         fifo_data[wr_ptr] <= bus.io_mem_rd_data;
      end
   end
endmodule

// File: tb/tb_packet_read_responder.sv
// Directed bench for packet_read_responder with a 2-cycle memory model and
// an in-order response scoreboard.
module tb_packet_read_responder;
   localparam int ID_W = 2, PAGE_W = 4, LINE_W = 2, DATA_W = 64;
   localparam int MEM_LAT = 2, RESP_DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   packet_read_responder_if #(.ID_W(ID_W), .PAGE_W(PAGE_W), .LINE_W(LINE_W),
      .DATA_W(DATA_W), .RESP_DEPTH(RESP_DEPTH)) bus ();

   packet_read_responder #(.ID_W(ID_W), .PAGE_W(PAGE_W), .LINE_W(LINE_W),
      .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .RESP_DEPTH(RESP_DEPTH)) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] word(input logic [5:0] a);
      return {8{2'b10, a}};
   endfunction

   // Memory model: data for address presented with rd_en appears 2 cycles later.
   logic       d1_en = 1'b0, d2_en = 1'b0;
   logic [5:0] d1_a = '0, d2_a = '0;
   always @(posedge clk) begin
      d1_en <= bus.io_mem_rd_en;
      d1_a  <= bus.io_mem_rd_addr;
      d2_en <= d1_en;
      d2_a  <= d1_a;
   end
   always_comb begin
      bus.io_mem_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
      if (d2_en) bus.io_mem_rd_data = word(d2_a);
   end

   // Scoreboard: expected tags in acceptance order; stability under stall.
   typedef struct packed {
      logic [1:0] id;
      logic [3:0] page;
      logic [1:0] line;
   } req_t;
   req_t        exp_q[$];
   logic        stall_prev = 1'b0;
   logic [71:0] bits_prev  = '0;

   always @(negedge clk) begin
      logic [71:0] cur;
      req_t e;
      cur = {bus.io_readResp_bits_requestor, bus.io_readResp_bits_req_page,
             bus.io_readResp_bits_req_line, bus.io_readResp_bits_data};
      if (rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (bus.io_readReq_valid && bus.io_readReq_ready) begin
            e = {bus.io_readReq_bits_requestor, bus.io_readReq_bits_page,
                 bus.io_readReq_bits_line};
            exp_q.push_back(e);
         end
         if (bus.io_readResp_valid) begin
            if (stall_prev) chk("resp_stable", cur, bits_prev);
            chk("resp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               chk("resp_tag", cur[71:64], e);
               chk("resp_data", cur[63:0], word({e.page, e.line}));
               if (bus.io_readResp_ready) void'(exp_q.pop_front());
            end
         end
         stall_prev = bus.io_readResp_valid & ~bus.io_readResp_ready;
         bits_prev  = cur;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive_req(input logic v, input logic [1:0] id, input logic [5:0] a);
      bus.io_readReq_valid          = v;
      bus.io_readReq_bits_requestor = id;
      bus.io_readReq_bits_page      = a[5:2];
      bus.io_readReq_bits_line      = a[1:0];
   endtask

   initial begin
      int acc;
      int n_acc;
      int vcnt;
      logic [5:0] a;
      rst = 1'b1;
      drive_req(1'b0, 2'd0, 6'd0);
      bus.io_readResp_ready = 1'b1;
      repeat (3) next_cycle();
      rst = 1'b0;
      mid();
      chk("rst_req_ready", bus.io_readReq_ready, 1);
      chk("rst_rd_en", bus.io_mem_rd_en, 0);
      chk("rst_rd_addr", bus.io_mem_rd_addr, 0);
      chk("rst_resp_valid", bus.io_readResp_valid, 0);
      chk("rst_resp_bits", {bus.io_readResp_bits_requestor, bus.io_readResp_bits_req_page,
                            bus.io_readResp_bits_req_line, bus.io_readResp_bits_data}, 0);
      chk("rst_outstanding", bus.io_outstanding, 0);

      // Single read: id 1, page 3, line 2 -> address 0x0E
      next_cycle(); drive_req(1'b1, 2'd1, 6'h0E); mid();
      chk("single_rd_en", bus.io_mem_rd_en, 1);
      chk("single_rd_addr", bus.io_mem_rd_addr, 6'h0E);
      next_cycle(); drive_req(1'b0, 2'd0, 6'h0E); mid();
      chk("single_idle_addr", bus.io_mem_rd_addr, 0);
      chk("single_occ_t1", bus.io_outstanding, 1);
      chk("single_valid_t1", bus.io_readResp_valid, 0);
      next_cycle(); mid();
      chk("single_occ_t2", bus.io_outstanding, 1);
      chk("single_valid_t2", bus.io_readResp_valid, 0);
      next_cycle(); mid();
      chk("single_valid_t3", bus.io_readResp_valid, 1);
      chk("single_occ_t3", bus.io_outstanding, 1);
      chk("single_id", bus.io_readResp_bits_requestor, 1);
      chk("single_page", bus.io_readResp_bits_req_page, 3);
      chk("single_line", bus.io_readResp_bits_req_line, 2);
      chk("single_data", bus.io_readResp_bits_data, word(6'h0E));
      next_cycle(); mid();
      chk("single_occ_t4", bus.io_outstanding, 0);
      chk("single_valid_t4", bus.io_readResp_valid, 0);

      // Streaming: 8 back-to-back requests, responses on 8 consecutive cycles
      for (int i = 0; i < 8; i++) begin
         next_cycle(); drive_req(1'b1, 2'(i % 4), {4'(4 + i / 4), 2'(i % 4)}); mid();
         chk("stream_req_ready", bus.io_readReq_ready, 1);
         chk("stream_resp_valid", bus.io_readResp_valid, (i >= 3) ? 1 : 0);
      end
      for (int j = 8; j < 12; j++) begin
         next_cycle(); drive_req(1'b0, 2'd0, 6'd0); mid();
         chk("stream_tail_valid", bus.io_readResp_valid, (j <= 10) ? 1 : 0);
      end

      // Backpressure: responses stalled, only RESP_DEPTH requests admitted
      next_cycle();
      bus.io_readResp_ready = 1'b0;
      a = 6'h24;
      drive_req(1'b1, 2'd2, a);
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         mid();
         if (bus.io_readReq_valid && bus.io_readReq_ready) begin
            acc++;
            a = a + 6'd1;
         end
         next_cycle();
         drive_req(1'b1, 2'd2, a);
      end
      chk("bp_accepted", acc, 4);
      bus.io_readResp_ready = 1'b1;
      mid();
      chk("bp_full_occ", bus.io_outstanding, 4);
      chk("bp_full_ready", bus.io_readReq_ready, 0);
      chk("bp_full_valid", bus.io_readResp_valid, 1);
      next_cycle(); mid();
      chk("bp_pop_occ", bus.io_outstanding, 3);
      chk("bp_pop_ready", bus.io_readReq_ready, 1);
      chk("bp_refire", bus.io_mem_rd_en, 1);
      next_cycle(); mid();
      chk("bp_fire_pop_occ", bus.io_outstanding, 3);
      next_cycle(); drive_req(1'b0, 2'd0, 6'd0);
      for (int k = 0; k < 30; k++) begin
         mid();
         if (bus.io_outstanding == 0) break;
         next_cycle();
      end
      chk("bp_drained", bus.io_outstanding, 0);

      // Reset mid-flight: two accepted reads are abandoned
      next_cycle(); drive_req(1'b1, 2'd3, 6'h11); mid();
      next_cycle(); drive_req(1'b1, 2'd0, 6'h12); mid();
      next_cycle(); drive_req(1'b0, 2'd0, 6'd0); rst = 1'b1; mid();
      next_cycle(); rst = 1'b0; mid();
      chk("midrst_ready", bus.io_readReq_ready, 1);
      chk("midrst_occ", bus.io_outstanding, 0);
      vcnt = 0;
      for (int k = 0; k < 6; k++) begin
         next_cycle(); mid();
         if (bus.io_readResp_valid) vcnt++;
      end
      chk("midrst_no_resp", vcnt, 0);

      // Random backpressure: 100 requests, scoreboard checks order/stability
      n_acc = 0;
      for (int k = 0; k < 4000 && n_acc < 100; k++) begin
         next_cycle();
         bus.io_readResp_ready = 1'($urandom_range(0, 1));
         drive_req($urandom_range(0, 3) != 0, 2'($urandom), 6'($urandom));
         mid();
         if (bus.io_readReq_valid && bus.io_readReq_ready) n_acc++;
      end
      chk("rand_accepted", n_acc, 100);
      next_cycle();
      drive_req(1'b0, 2'd0, 6'd0);
      bus.io_readResp_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         mid();
         if (bus.io_outstanding == 0 && !bus.io_readResp_valid) break;
         next_cycle();
      end
      chk("rand_drained_occ", bus.io_outstanding, 0);
      chk("rand_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
